// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
//   Memory-mapped I/O peripheral beside the block RAM on the CPU data port.
//   Decodes the I/O window (top two address bits both 1) and provides an
//   LED register, synchronized and debounced switches, latched switch
//   rising-edge events, and a prescaled 16-bit timer with a compare flag.
//
//   Register map (offset = addr[2:0], window aliases every 8 words):
//     0 SW   RO    {0, sw_db[7:0]}
//     1 LED  RW    {0, led[7:0]}
//     2 EVT  W1C   {0, evt[7:0]}
//     3 TMR  RW    timer[15:0]; a write also clears the prescaler
//     4 CMP  RW    cmp[15:0]
//     5 STAT W1C   {0, cmp_hit}
//     6 MASK RW    {0, mask[8:0]} when MMIO_IRQ_EN is defined, else reads 0
//     7      reads 0, writes ignored
//
//   Optional feature macro: MMIO_IRQ_EN (adds the MASK register and irq).
//
//   Ports:
//     clk       system clock, rising edge
//     reset     synchronous, active-low reset
//     addr      CPU memory address
//     wr_data   CPU write data
//     we        CPU write enable
//     switches  raw asynchronous board switches
//     io_sel    combinational window decode; top level muxes rd_data over BRAM
//     rd_data   combinational read data, 0 outside the window
//     LEDs      LED register contents
//     irq       registered interrupt request (MMIO_IRQ_EN only)

module mmio_io_ctrl #(
  parameter int WIDTH           = 16,
  parameter int ADDR_WIDTH      = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PRESCALE        = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  we,
  input  logic [7:0]            switches,
`ifdef MMIO_IRQ_EN
  output logic                  irq,
`endif
  output logic                  io_sel,
  output logic [WIDTH-1:0]      rd_data,
  output logic [7:0]            LEDs
);

  localparam logic [2:0] OFF_SW   = 3'd0;
  localparam logic [2:0] OFF_LED  = 3'd1;
  localparam logic [2:0] OFF_EVT  = 3'd2;
  localparam logic [2:0] OFF_TMR  = 3'd3;
  localparam logic [2:0] OFF_CMP  = 3'd4;
  localparam logic [2:0] OFF_STAT = 3'd5;
`ifdef MMIO_IRQ_EN
  localparam logic [2:0] OFF_MASK = 3'd6;
`endif

  localparam logic [31:0] DCNT_LAST = 32'(DEBOUNCE_CYCLES - 1);
  // Keep the prescaler at least one bit wide so PRESCALE = 1 still builds.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  logic [2:0]    offset;
  logic          wr;
  logic          wr_led, wr_evt, wr_tmr, wr_cmp, wr_stat;

  logic [7:0]    led;
  logic [7:0]    sw_s1, sw_s2, sw_cand, sw_db;
  logic [31:0]   dcnt;
  logic          accept;
  logic [7:0]    sw_rise;
  logic [7:0]    evt;

  logic [15:0]   timer, timer_next, cmp;
  logic [PW-1:0] pcnt;
  logic          pcnt_wrap, timer_step;
  logic          cmp_hit;

`ifdef MMIO_IRQ_EN
  logic [8:0]    mask;
`endif

  // Address bits between the window decode and the offset only alias.
  logic unused_bits;
  assign unused_bits = ^{addr, wr_data};

  assign io_sel  = addr[ADDR_WIDTH-1] & addr[ADDR_WIDTH-2];
  assign offset  = addr[2:0];
  assign wr      = we & io_sel;
  assign wr_led  = wr && (offset == OFF_LED);
  assign wr_evt  = wr && (offset == OFF_EVT);
  assign wr_tmr  = wr && (offset == OFF_TMR);
  assign wr_cmp  = wr && (offset == OFF_CMP);
  assign wr_stat = wr && (offset == OFF_STAT);

  assign LEDs = led;

  always_ff @(posedge clk) begin
    if (!reset) begin
      led <= 8'h00;
    end else if (wr_led) begin
      led <= wr_data[7:0];
    end
  end

  // Two-flop synchronizer followed by a whole-vector debouncer: any change
  // of the synced vector restarts the shared stability counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_s1   <= 8'h00;
      sw_s2   <= 8'h00;
      sw_cand <= 8'h00;
      sw_db   <= 8'h00;
      dcnt    <= 32'd0;
    end else begin
      sw_s1 <= switches;
      sw_s2 <= sw_s1;
      if (sw_s2 != sw_cand) begin
        sw_cand <= sw_s2;
        dcnt    <= 32'd0;
      end else if (dcnt == DCNT_LAST) begin
        sw_db <= sw_cand;
      end else begin
        dcnt <= dcnt + 32'd1;
      end
    end
  end

  // Rising edges of the debounced vector, aligned with the sw_db update.
  assign accept  = (sw_s2 == sw_cand) && (dcnt == DCNT_LAST);
  assign sw_rise = accept ? (sw_cand & ~sw_db) : 8'h00;

  // Event latches: W1C clear, a new rising edge in the same cycle wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      evt <= 8'h00;
    end else begin
      evt <= (evt & ~(wr_evt ? wr_data[7:0] : 8'h00)) | sw_rise;
    end
  end

  // Next timer value: a software load beats the prescaler tick.
  assign pcnt_wrap = (pcnt == PCNT_LAST);

  always_comb begin
    timer_next = timer;
    timer_step = 1'b0;
    if (wr_tmr) begin
      timer_next = wr_data[15:0];
      timer_step = 1'b1;
    end else if (pcnt_wrap) begin
      timer_next = timer + 16'd1;
      timer_step = 1'b1;
    end
  end

  // Timer, compare register and the sticky compare-hit flag. The hit is
  // raised only when the timer actually moves onto the compare value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer   <= 16'h0000;
      pcnt    <= '0;
      cmp     <= 16'hFFFF;
      cmp_hit <= 1'b0;
    end else begin
      timer <= timer_next;
      if (wr_tmr || pcnt_wrap) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + 1'b1;
      end
      if (wr_cmp) begin
        cmp <= wr_data[15:0];
      end
      cmp_hit <= (cmp_hit & ~(wr_stat & wr_data[0])) |
                 (timer_step && (timer_next == cmp));
    end
  end

`ifdef MMIO_IRQ_EN
  // Interrupt mask and request; irq follows the flags one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask <= 9'h000;
      irq  <= 1'b0;
    end else begin
      if (wr && (offset == OFF_MASK)) begin
        mask <= wr_data[8:0];
      end
      irq <= (|(evt & mask[7:0])) | (cmp_hit & mask[8]);
    end
  end
`endif

  // Zero-latency read mux, side-effect free.
  always_comb begin
    rd_data = '0;
    if (io_sel) begin
      case (offset)
        OFF_SW:   rd_data[7:0]  = sw_db;
        OFF_LED:  rd_data[7:0]  = led;
        OFF_EVT:  rd_data[7:0]  = evt;
        OFF_TMR:  rd_data[15:0] = timer;
        OFF_CMP:  rd_data[15:0] = cmp;
        OFF_STAT: rd_data[0]    = cmp_hit;
`ifdef MMIO_IRQ_EN
        OFF_MASK: rd_data[8:0]  = mask;
`endif
        default:  rd_data       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl
//   Directed steps followed by randomized traffic, compared against a
//   behavioural model: the switch path is a history of raw samples, the
//   timer is "load value + elapsed cycles / PRESCALE".

module tb_mmio_io_ctrl;

  localparam int WIDTH = 16;
  localparam int AW    = 10;
  localparam int DEB   = 8;
  localparam int PRE   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wr_data;
  logic             we;
  logic [7:0]       switches;
  logic             io_sel;
  logic [WIDTH-1:0] rd_data;
  logic [7:0]       LEDs;
`ifdef MMIO_IRQ_EN
  logic             irq;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Behavioural model state
  logic [7:0]  m_led, m_evt, m_db;
  logic        m_hit;
  int          m_tbase, m_elapsed;
  logic [15:0] m_cmp;
  logic [7:0]  hist[$];
`ifdef MMIO_IRQ_EN
  logic [8:0]  m_mask;
  logic        m_irq;
`endif

  // Random-phase variables
  logic [9:0]  r_addr;
  logic [15:0] r_data;
  logic        r_we, r_rst;
  logic [7:0]  r_sw;

  mmio_io_ctrl #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DEB), .PRESCALE(PRE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wr_data(wr_data),
    .we(we),
    .switches(switches),
`ifdef MMIO_IRQ_EN
    .irq(irq),
`endif
    .io_sel(io_sel),
    .rd_data(rd_data),
    .LEDs(LEDs)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] modelTimer();
    return 16'(m_tbase + m_elapsed / PRE);
  endfunction

  function automatic logic [15:0] modelRead(input logic [9:0] a);
    logic [15:0] v;
    v = 16'h0000;
    if (a >= 10'h300) begin
      case (a[2:0])
        3'd0: v = {8'h00, m_db};
        3'd1: v = {8'h00, m_led};
        3'd2: v = {8'h00, m_evt};
        3'd3: v = modelTimer();
        3'd4: v = m_cmp;
        3'd5: v = {15'h0000, m_hit};
`ifdef MMIO_IRQ_EN
        3'd6: v = {7'h00, m_mask};
`endif
        default: v = 16'h0000;
      endcase
    end
    return v;
  endfunction

  task automatic modelReset();
    m_led = 8'h00; m_evt = 8'h00; m_db = 8'h00; m_hit = 1'b0;
    m_tbase = 0; m_elapsed = 0; m_cmp = 16'hFFFF;
    // Synchronizer and candidate all hold zero; nothing older is known.
    hist.delete();
    hist.push_back(8'h00); hist.push_back(8'h00); hist.push_back(8'h00);
`ifdef MMIO_IRQ_EN
    m_mask = 9'h000; m_irq = 1'b0;
`endif
  endtask

  // Drive one cycle of inputs, advance the model by one clock, then wait
  // past the edge so outputs can be sampled.
  task automatic applyStimulus(input logic [9:0] a, input logic [15:0] d,
                               input logic w, input logic [7:0] sw,
                               input logic rst_n);
    logic       wr, moved, same;
    logic [2:0] off;
    logic [7:0] db_new, rise;
    logic [15:0] t_new;
    int         n;
`ifdef MMIO_IRQ_EN
    logic       irq_new;
`endif
    addr = a; wr_data = d; we = w; switches = sw; reset = rst_n;
    if (!rst_n) begin
      modelReset();
    end else begin
      wr  = w && (a >= 10'h300);
      off = a[2:0];
      // Switch accepted once the synced input (two samples back) has been
      // stable for DEB+1 consecutive samples.
      hist.push_back(sw);
      if (hist.size() > DEB + 3) void'(hist.pop_front());
      db_new = m_db;
      n = hist.size() - 2;
      if (n >= DEB + 1) begin
        same = 1'b1;
        for (int i = n - DEB - 1; i < n; i++)
          if (hist[i] != hist[n-1]) same = 1'b0;
        if (same) db_new = hist[n-1];
      end
      rise = db_new & ~m_db;
`ifdef MMIO_IRQ_EN
      irq_new = (|(m_evt & m_mask[7:0])) | (m_hit & m_mask[8]);
`endif
      if (wr && off == 3'd3) begin
        m_tbase = int'(d); m_elapsed = 0; moved = 1'b1;
      end else begin
        m_elapsed++;
        moved = ((m_elapsed % PRE) == 0);
      end
      t_new = modelTimer();
      m_hit = (m_hit && !(wr && off == 3'd5 && d[0])) || (moved && t_new == m_cmp);
      m_evt = (m_evt & ~((wr && off == 3'd2) ? d[7:0] : 8'h00)) | rise;
      if (wr && off == 3'd1) m_led = d[7:0];
      if (wr && off == 3'd4) m_cmp = d;
`ifdef MMIO_IRQ_EN
      if (wr && off == 3'd6) m_mask = d[8:0];
      m_irq = irq_new;
`endif
      m_db = db_new;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic readCheck(input string tag, input logic [9:0] a,
                           input logic [15:0] exp);
    addr = a; we = 1'b0;
    #1;
    checkOutput(tag, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    $display("[TB] mmio_io_ctrl bench start");

    // Reset and reset values
    applyStimulus(10'h000, 16'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(10'h000, 16'h0, 1'b0, 8'h00, 1'b0);
    applyStimulus(10'h000, 16'h0, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_leds", 32'(LEDs), 32'h0);
    readCheck("rst_sw", 10'h300, 16'h0000);
    readCheck("rst_evt", 10'h302, 16'h0000);
    readCheck("rst_tmr", 10'h303, 16'h0000);
    readCheck("rst_cmp", 10'h304, 16'hFFFF);
    addr = 10'h0FF; #1;
    checkOutput("iosel_0ff", 32'(io_sel), 32'h0);
    addr = 10'h300; #1;
    checkOutput("iosel_300", 32'(io_sel), 32'h1);

    // LED write inside and outside the window
    applyStimulus(10'h301, 16'hA5C3, 1'b1, 8'h00, 1'b1);
    checkOutput("led_write", 32'(LEDs), 32'hC3);
    readCheck("led_read", 10'h301, 16'h00C3);
    applyStimulus(10'h201, 16'h1234, 1'b1, 8'h00, 1'b1);
    checkOutput("led_outside", 32'(LEDs), 32'hC3);
    readCheck("rd_outside", 10'h201, 16'h0000);

    // Short glitch rejected, then a held change accepted 10 cycles on
    for (int k = 0; k < 5; k++) begin
      applyStimulus(10'h300, 16'h0, 1'b0, 8'h01, 1'b1);
      readCheck("sw_glitch", 10'h300, 16'h0000);
    end
    for (int k = 0; k < 12; k++) begin
      applyStimulus(10'h300, 16'h0, 1'b0, 8'h00, 1'b1);
      readCheck("sw_low", 10'h300, 16'h0000);
    end
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(10'h300, 16'h0, 1'b0, 8'h01, 1'b1);
      readCheck("sw_hold", 10'h300, modelRead(10'h300));
      if (k == 10) readCheck("sw_before_accept", 10'h300, 16'h0000);
      if (k == 11) readCheck("sw_accept", 10'h300, 16'h0001);
    end
    readCheck("evt_bit0", 10'h302, 16'h0001);

    // W1C of bit 0 in the same cycle bit 1 rises
    for (int k = 0; k < 10; k++)
      applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    applyStimulus(10'h302, 16'h0001, 1'b1, 8'h03, 1'b1);
    readCheck("evt_w1c_set", 10'h302, 16'h0002);
    readCheck("sw_both", 10'h300, 16'h0003);

    // Timer wrap and compare hit
    applyStimulus(10'h305, 16'h0001, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h303, 16'hFFFE, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h304, 16'h0000, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    readCheck("tmr_ffff", 10'h303, 16'hFFFF);
    readCheck("stat_pre", 10'h305, 16'h0000);
    applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    readCheck("tmr_wrap", 10'h303, 16'h0000);
    readCheck("stat_hit", 10'h305, 16'h0001);
    applyStimulus(10'h305, 16'h0001, 1'b1, 8'h03, 1'b1);
    readCheck("stat_clr", 10'h305, 16'h0000);

`ifdef MMIO_IRQ_EN
    // Compare-masked interrupt, set via timer load
    applyStimulus(10'h306, 16'h0100, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h304, 16'h1234, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h303, 16'h1234, 1'b1, 8'h03, 1'b1);
    readCheck("load_hit", 10'h305, 16'h0001);
    applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    checkOutput("irq_set", 32'(irq), 32'h1);
    applyStimulus(10'h305, 16'h0001, 1'b1, 8'h03, 1'b1);
    applyStimulus(10'h300, 16'h0, 1'b0, 8'h03, 1'b1);
    checkOutput("irq_clr", 32'(irq), 32'h0);
    readCheck("mask_read", 10'h306, 16'h0100);
`else
    applyStimulus(10'h306, 16'hFFFF, 1'b1, 8'h03, 1'b1);
    readCheck("off6_zero", 10'h306, 16'h0000);
    applyStimulus(10'h307, 16'hFFFF, 1'b1, 8'h03, 1'b1);
    readCheck("off7_zero", 10'h307, 16'h0000);
`endif

    // Randomized traffic against the model
    r_sw = 8'h03;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(15) == 0) r_sw = 8'($urandom);
      if ($urandom_range(3) != 0) r_addr = {2'b11, 5'($urandom), 3'($urandom)};
      else                        r_addr = 10'($urandom);
      r_data = 16'($urandom);
      if (r_addr[2:0] == 3'd3 && $urandom_range(1) == 1) r_data = m_cmp - 16'd1;
      r_we  = ($urandom_range(1) == 1);
      r_rst = ($urandom_range(99) != 0);
      applyStimulus(r_addr, r_data, r_we, r_sw, r_rst);
      checkOutput("rnd_leds", 32'(LEDs), 32'(m_led));
      checkOutput("rnd_iosel", 32'(io_sel), 32'(r_addr >= 10'h300));
      checkOutput("rnd_rd", 32'(rd_data), 32'(modelRead(r_addr)));
`ifdef MMIO_IRQ_EN
      checkOutput("rnd_irq", 32'(irq), 32'(m_irq));
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
